// File: rtl/craft_cipher_core.sv
// Iterative CRAFT tweakable block cipher: 64-bit block, 128-bit key, 64-bit tweak, 32 rounds.
// Define CRAFT_DEC_EN to compile in decryption (selected by `mode` at accept); otherwise encrypt only.

module craft_key_schedule (
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic [1:0]   r,
    output logic [63:0]  tk
);
    // Tweak nibble permutation Q; nibble 0 sits in bits [63:60].
    localparam logic [63:0] Q_TAB = 64'hcaf5_e892_b374_601d;

    function automatic logic [63:0] permute_q(input logic [63:0] t);
        logic [63:0] o;
        int          q;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            q = int'(Q_TAB[63-4*i -: 4]);
            o[63-4*i -: 4] = t[63-4*q -: 4];
        end
        return o;
    endfunction

    logic [63:0] tweak_q;

    assign tweak_q = permute_q(tweak);

    always_comb begin
        tk = '0;
        case (r)
            2'd0: tk = key[127:64] ^ tweak;
            2'd1: tk = key[63:0]   ^ tweak;
            2'd2: tk = key[127:64] ^ tweak_q;
            2'd3: tk = key[63:0]   ^ tweak_q;
            default: tk = '0;
        endcase
    end
endmodule

module craft_cipher_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic [63:0]  din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  dout,
    output logic         busy
);
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
        $error("craft_cipher_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    localparam logic [7:0]  LAST_RND = 8'(32 - ROUNDS_PER_CYCLE);
    localparam logic [7:0]  STEP     = 8'(ROUNDS_PER_CYCLE);
    localparam logic [63:0] P_TAB    = 64'hfcde_a98b_6547_1230;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [7:0]    rnd;
    logic [63:0]   blk;
    logic [127:0]  key_reg;
    logic [63:0]   tweak_reg;
    logic [63:0]   chain [ROUNDS_PER_CYCLE+1];

    // Rows are 16-bit slices, so column-wise nibble XORs become row-wide XORs.
    function automatic logic [63:0] mix_column(input logic [63:0] s);
        return {s[63:48] ^ s[31:16] ^ s[15:0], s[47:32] ^ s[15:0], s[31:0]};
    endfunction

    function automatic logic [63:0] permute_nibbles(input logic [63:0] s);
        logic [63:0] o;
        int          p;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            p = int'(P_TAB[63-4*i -: 4]);
            o[63-4*i -: 4] = s[63-4*p -: 4];
        end
        return o;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hc;  4'h1: y = 4'ha;  4'h2: y = 4'hd;  4'h3: y = 4'h3;
            4'h4: y = 4'he;  4'h5: y = 4'hb;  4'h6: y = 4'hf;  4'h7: y = 4'h7;
            4'h8: y = 4'h8;  4'h9: y = 4'h9;  4'ha: y = 4'h1;  4'hb: y = 4'h5;
            4'hc: y = 4'h0;  4'hd: y = 4'h2;  4'he: y = 4'h4;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[4*i +: 4] = sbox(s[4*i +: 4]);
        end
        return o;
    endfunction

    // RC[i] = {a_i, b_i} from the 4-bit and 3-bit round-constant LFSRs.
    function automatic logic [7:0] round_const(input logic [4:0] i);
        logic [7:0] c;
        case (i)
            5'd0:  c = 8'h11;  5'd1:  c = 8'h84;  5'd2:  c = 8'h42;  5'd3:  c = 8'h25;
            5'd4:  c = 8'h96;  5'd5:  c = 8'hc7;  5'd6:  c = 8'h63;  5'd7:  c = 8'hb1;
            5'd8:  c = 8'h54;  5'd9:  c = 8'ha2;  5'd10: c = 8'hd5;  5'd11: c = 8'he6;
            5'd12: c = 8'hf7;  5'd13: c = 8'h73;  5'd14: c = 8'h31;  5'd15: c = 8'h14;
            5'd16: c = 8'h82;  5'd17: c = 8'h45;  5'd18: c = 8'h26;  5'd19: c = 8'h97;
            5'd20: c = 8'hc3;  5'd21: c = 8'h61;  5'd22: c = 8'hb4;  5'd23: c = 8'h52;
            5'd24: c = 8'ha5;  5'd25: c = 8'hd6;  5'd26: c = 8'he7;  5'd27: c = 8'hf3;
            5'd28: c = 8'h71;  5'd29: c = 8'h34;  5'd30: c = 8'h12;  default: c = 8'h85;
        endcase
        return c;
    endfunction

    function automatic logic [63:0] craft_round(input logic [63:0] s, input logic [7:0] rc,
                                                input logic [63:0] tk, input logic last);
        logic [63:0] t;
        t = mix_column(s) ^ {16'h0, rc, 40'h0} ^ tk;
        return last ? t : sbox_layer(permute_nibbles(t));
    endfunction

`ifdef CRAFT_DEC_EN
    logic mode_reg;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign chain[0] = blk;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [4:0]  ridx;
        logic [1:0]  ks_r;
        logic [4:0]  cidx;
        logic [63:0] tk_raw;
        logic [63:0] tk;

        assign ridx = rnd[4:0] + 5'(j);
`ifdef CRAFT_DEC_EN
        // Decryption replays the same round with reversed constants and MixColumn-ed tweakeys.
        assign ks_r = mode_reg ? (2'd3 - ridx[1:0]) : ridx[1:0];
        assign cidx = mode_reg ? (5'd31 - ridx) : ridx;
        assign tk   = mode_reg ? mix_column(tk_raw) : tk_raw;
`else
        assign ks_r = ridx[1:0];
        assign cidx = ridx;
        assign tk   = tk_raw;
`endif

        craft_key_schedule u_ks (
            .key   (key_reg),
            .tweak (tweak_reg),
            .r     (ks_r),
            .tk    (tk_raw)
        );

        assign chain[j+1] = craft_round(chain[j], round_const(cidx), tk, ridx == 5'd31);
    end

    assign in_ready = (state == IDLE) & ~rst;
    assign dout     = blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            blk       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        rnd   <= '0;
                        blk   <= din;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    blk <= chain[ROUNDS_PER_CYCLE];
                    if (rnd == LAST_RND) begin
                        state     <= DONE;
                        rnd       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands are captured only on accept and held for the whole operation.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            key_reg   <= key;
            tweak_reg <= tweak;
`ifdef CRAFT_DEC_EN
            mode_reg  <= mode;
`endif
        end
    end
endmodule

// File: doc/craft_cipher_core.md
# craft_cipher_core

Iterative CRAFT tweakable block cipher engine: 64-bit block, 128-bit key, 64-bit tweak, 32 rounds, with a parametrised number of rounds unrolled per clock and optional decryption. It reuses `craft_key_schedule` for per-round tweakeys and wraps the datapath in a valid/ready stream interface. It sits between the board-level `top` and the `display` block, replacing the bare key-schedule instance.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds applied per RUN cycle.
  - Legal values: 1, 2, 4, 8, 16, 32.
  - Any other value is an elaboration error (`$error`).
- `clk` in 1: the block's only clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input request valid.
- `in_ready` out 1: block can accept a request.
- `mode` in 1: 0 = encrypt, 1 = decrypt. Sampled only at accept.
- `key` in 128: cipher key. Sampled only at accept.
- `tweak` in 64: tweak. Sampled only at accept.
- `din` in 64: plaintext or ciphertext. Sampled only at accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `dout` out 64: result.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
  - `in_ready = (state==IDLE) & ~rst`.
  - `out_valid = (state==DONE)`.
- IDLE to RUN on `in_valid & in_ready`:
  - Latch `key`, `tweak` and `mode`.
  - Load `din` into the 64-bit state register.
  - Set the 8-bit round counter `rnd` to 0.
- Each RUN cycle applies rounds `rnd .. rnd+ROUNDS_PER_CYCLE-1`, then sets `rnd += ROUNDS_PER_CYCLE`.
- RUN to DONE in the cycle whose last applied round is 31. `rnd` is then cleared.
- DONE to IDLE on `out_ready`.
- Round `i` in encrypt mode applies, in order: MixColumn, AddConstant(RC[i]), AddTweakey(TK[i mod 4]), PermuteNibbles, S-box.
  - Round 31 omits PermuteNibbles and the S-box.
- Round `i` in decrypt mode uses the identical datapath with three changes:
  - Constant index is 31−i.
  - Tweakey is TK[(31−i) mod 4] passed through MixColumn.
  - This works because all CRAFT components are involutions.
- Tweakeys come from `ROUNDS_PER_CYCLE` instances of `craft_key_schedule`. Instance j is driven with `r = rnd+j` (encrypt) or `31−rnd−j` (decrypt).
- `dout` is the state register, held stable through DONE. It is meaningful only while `out_valid`=1.
- While in RUN or DONE, `in_valid` is ignored and input-port changes have no effect.
- Back-to-back requests are not overlapped.

## Timing
- Reset (`rst` high at a clock edge) sets:
  - state = IDLE, `rnd` = 0, state register = 0.
  - `out_valid` = 0, `dout` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high.
- Reset asserted mid-RUN or in DONE aborts the operation.
  - No `out_valid` pulse follows.
  - `in_ready` = 1 in the first cycle after `rst` falls.
- Latency: accept at edge N gives `out_valid` high after edge N+32/ROUNDS_PER_CYCLE.
  - RPC=1: N+32. RPC=4: N+8. RPC=32: N+1.
- Throughput with `out_ready` held high: one block per 32/ROUNDS_PER_CYCLE+2 cycles.
- Backpressure: while `out_valid & ~out_ready`, DONE is held and `dout` stays constant.
- `in_valid` and `out_ready` arriving in the same cycle: only the DONE-to-IDLE transition occurs. The new request is accepted no earlier than the next cycle.
- Critical path grows linearly with ROUNDS_PER_CYCLE. No internal pipelining.

## Configuration
- `CRAFT_DEC_EN` defined:
  - The decrypt path is compiled in: constant-index reversal, TK MixColumn and the `mode` register.
- `CRAFT_DEC_EN` undefined:
  - `mode` is an unconnected input and the block always encrypts.
  - No MixColumn on tweakeys and no `mode` register is synthesised.

## Test plan
- Reset abort: accept a request, assert `rst` for 2 cycles at RUN cycle 5.
  - Expect `out_valid` never pulses, `dout`=0.
  - Expect `in_ready`=1 one cycle after `rst` falls.
- Latency: RPC=1, accept at cycle 10, `out_ready`=1.
  - Expect `out_valid` high exactly at cycle 42 for one cycle.
  - Repeat with RPC=4: expect cycle 18.
- Round-trip (`CRAFT_DEC_EN` defined):
  - K=0x000102030405060708090a0b0c0d0e0f, T=0x0011223344556677, P=0x0123456789abcdef.
  - Encrypt, then decrypt the produced C with the same K and T.
  - Expect `dout`=0x0123456789abcdef and C≠P.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1.
  - Expect `dout` and `out_valid` stable, `in_ready`=0, no second accept.
  - Release `out_ready`: expect IDLE next cycle.
- Cross-config equivalence: the same 16 random (K, T, P, mode) vectors through RPC=1 and RPC=8.
  - Expect identical `dout`, matching the software CRAFT reference model.
- Macro off: `CRAFT_DEC_EN` undefined, send the round-trip vector with `mode`=1.
  - Expect `dout` equal to the `mode`=0 encryption result.
